mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequential arbiter that shares one single-port, fixed-latency memory between the fetch stage (instruction reads) and the memory stage (lw/sw data accesses) of the five-stage pipeline. It sits between the pipeline and the unified memory, driven by the decoded MemRead/MemWrite controls. It serialises accesses with fixed data-over-instruction priority. It returns per-requester acknowledge pulses and produces the stall signals the pipeline registers use to hold while an access is outstanding.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from mem_req to valid mem_rdata; legal range 1..15

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  instruction word, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse to fetch
- dm_read  in  1  MemRead of the MEM-stage instruction, held until dm_ack
- dm_write  in  1  MemWrite of the MEM-stage instruction, held until dm_ack
- dm_addr  in  ADDR_W  data address (ALU result)
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid while dm_ack=1
- dm_ack  out  1  one-cycle completion pulse to MEM stage
- mem_req  out  1  one-cycle access strobe to memory
- mem_we  out  1  write enable, qualified by mem_req
- mem_addr  out  ADDR_W  registered access address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data, valid exactly MEM_LAT cycles after mem_req
- stall_if  out  1  if_req & ~if_ack (combinational)
- stall_mem  out  1  (dm_read | dm_write) & ~dm_ack (combinational)

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Owner register: OWN_IF or OWN_DM. Latency counter: 4 bits.
- IDLE: arbitration happens here only.
  - If dm_read | dm_write: owner=DM. Latch dm_addr and dm_wdata. Set mem_we=dm_write. Go to ISSUE.
  - Else if if_req: owner=IF. Latch if_addr. mem_we=0. Go to ISSUE.
  - Else stay in IDLE.
- ISSUE: mem_req=1 for this cycle only. Load counter with MEM_LAT. Go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle where the counter equals 1:
  - capture mem_rdata into the owner's rdata register (writes capture nothing; rdata is held at 0);
  - go to DONE.
- DONE: pulse the owner's ack for one cycle, then go to IDLE. No arbitration takes place in DONE, so a request still held during its ack cycle is never granted twice.
- dm_read=1 and dm_write=1 together is illegal. It is treated as a write, and dm_rdata=0.
- A requester that drops its request mid-transaction does not abort it. The access completes and the ack still pulses.
- There is no fairness: IF is starved for as long as the DM request is held. This is acceptable because a DM request stalls the whole pipe.
- mem_addr, mem_wdata and mem_we hold their latched values until the next grant.

## Timing
- Request sampled in IDLE at cycle S:
  - mem_req at S+1;
  - mem_rdata captured at S+1+MEM_LAT;
  - ack and rdata valid at S+2+MEM_LAT;
  - IDLE again at S+3+MEM_LAT.
- Throughput is one access per MEM_LAT+3 cycles. A back-to-back request is sampled at S+3+MEM_LAT at the earliest.
- rdata outputs are registered and valid only while their ack is high; their value is undefined otherwise.
- Reset, asynchronous and effective immediately:
  - state=IDLE, counter=0, owner=OWN_IF;
  - mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata all 0.
- Reset mid-transaction abandons the access. No ack is issued, and any later memory response is ignored.
- stall_if and stall_mem follow the inputs combinationally and both are 0 in reset when no request is applied.

## Structure
- A shared pipeline package holds:
  - the state enum (IDLE/ISSUE/WAIT/DONE);
  - the owner encoding (OWN_IF=0, OWN_DM=1);
  - the MEM_LAT upper-bound constant, also used by the cache and memory models.
- Single module. No sub-module is needed; the latency counter stays inline.

## Test plan
- Fetch only, MEM_LAT=2:
  - stimulus: if_req=1, if_addr=0x40 at cycle 0; memory returns 0x20080005;
  - response: mem_req=1, mem_we=0, mem_addr=0x40 at cycle 1; if_ack=1 and if_rdata=0x20080005 at cycle 4; stall_if=1 during cycles 0-3.
- Contention:
  - stimulus: if_req and dm_read asserted together, dm_addr=0x100;
  - response: DM is served first (dm_ack at cycle 4); the IF access is sampled at cycle 5 and acked at cycle 9.
- Store:
  - stimulus: dm_write=1, dm_addr=0x8, dm_wdata=0xDEADBEEF;
  - response: mem_req=1, mem_we=1, mem_addr=0x8, mem_wdata=0xDEADBEEF at cycle 1; dm_ack at cycle 4 with dm_rdata=0.
- Held request:
  - stimulus: if_req kept high through and after if_ack;
  - response: exactly one mem_req per ack, with the next mem_req no earlier than ack+2.
- Reset mid-transaction:
  - stimulus: rst asserted during WAIT;
  - response: all outputs 0 immediately, no ack; after release, a fresh if_req completes normally.
- MEM_LAT=1 and MEM_LAT=15 builds: ack arrives at S+3 and S+17 respectively.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline definitions for the unified-memory port: the arbiter FSM
// states, the owner encoding and the memory-latency bound.
package mem_port_arbiter_pkg;

  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, MEM-stage, memory and stall signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipe/memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and MEM-stage accesses onto one fixed-latency memory port,
// data side first, and raises the pipeline stalls while an access is pending.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  state_t            r_state;
  state_t            w_state_next;
  owner_t            r_owner;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_ack;
  logic              r_dm_ack;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic w_dm_any;
  logic w_grant_dm;
  logic w_grant_if;
  logic w_capture;

  assign w_dm_any = bus.dm_read | bus.dm_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_grant_dm   = 1'b0;
    w_grant_if   = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dm_any) begin
          w_grant_dm   = 1'b1;
          w_state_next = ISSUE;
        end else if (bus.if_req) begin
          w_grant_if   = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: w_state_next = WAIT;
      WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_capture    = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= OWN_IF;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_mem_req <= w_grant_dm | w_grant_if;
      r_if_ack  <= w_capture && (r_owner == OWN_IF);
      r_dm_ack  <= w_capture && (r_owner == OWN_DM);

      // Read+write together is treated as a write, so dm_write alone sets mem_we.
      if (w_grant_dm) begin
        r_owner     <= OWN_DM;
        r_mem_addr  <= bus.dm_addr;
        r_mem_wdata <= bus.dm_wdata;
        r_mem_we    <= bus.dm_write;
      end else if (w_grant_if) begin
        r_owner    <= OWN_IF;
        r_mem_addr <= bus.if_addr;
        r_mem_we   <= 1'b0;
      end

      if (r_state == ISSUE)     r_cnt <= CNT_W'(MEM_LAT);
      else if (r_state == WAIT) r_cnt <= r_cnt - CNT_W'(1);

      if (w_capture) begin
        if (r_owner == OWN_IF) r_if_rdata <= bus.mem_rdata;
        else                   r_dm_rdata <= r_mem_we ? '0 : bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.stall_if  = bus.if_req & ~r_if_ack;
  assign bus.stall_mem = w_dm_any & ~r_dm_ack;

endmodule
